// File: rtl/step_controller.sv
// Processor single-step / burst / free-run pulse generator driven by a debounced key strobe.
// StepEn and Busy are decoded from registered state only, so no input reaches them combinationally.
module step_controller #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 23
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Strobe,
  input  logic [1:0]       Mode,
  input  logic [7:0]       BurstLen,
  output logic             StepEn,
  output logic             Busy,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StepCount
);

  localparam int unsigned REM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_BURST = 2'd2,
    ST_FREE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_FREE   = 2'b10;
  localparam logic [1:0] MODE_HALT   = 2'b11;

  localparam logic [DIV_W-1:0] DIV_ALL_ONES = {DIV_W{1'b1}};

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_en;

  // State register and datapath flops
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulse decode from registered state only
  always_comb begin
    step_en = 1'b0;
    case (state_q)
      ST_STEP:  step_en = 1'b1;
      ST_BURST: step_en = 1'b1;
      ST_FREE:  step_en = (div_q == DIV_ALL_ONES);
      default:  step_en = 1'b0;
    endcase
  end

  // Next-state, burst remaining and free-run divider
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;

    case (state_q)
      ST_IDLE: begin
        if (Strobe) begin
          case (Mode)
            MODE_SINGLE: state_d = ST_STEP;
            MODE_BURST: begin
              if (BurstLen != 8'd0) begin
                state_d = ST_BURST;
                rem_d   = BurstLen;
              end
            end
            MODE_FREE: begin
              state_d = ST_FREE;
              div_d   = '0;
            end
            MODE_HALT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
          endcase
        end
      end

      ST_STEP: state_d = ST_IDLE;

      ST_BURST: begin
        rem_d = rem_q - REM_W'(1);
        // Abort leaves Remaining cleared so a later burst starts from a clean value
        if (Strobe) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (rem_q == REM_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      ST_FREE: begin
        div_d = div_q + DIV_W'(1);
        if (Strobe) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Running total of issued steps, wrapping naturally
  always_comb begin
    cnt_d = cnt_q;
    if (step_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign StepEn    = step_en;
  assign Busy      = (state_q != ST_IDLE);
  assign State     = state_q;
  assign StepCount = cnt_q;

endmodule
